// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one shared 32-bit ALU with a programmable execute delay.
// Define ALU_FLAGS_EN to add registered zero/negative result flags (rsp_zero, rsp_neg).
module alu_share_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter bit FIXED_PRIO  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_illegal,
`ifdef ALU_FLAGS_EN
  output logic        rsp_zero,
  output logic        rsp_neg,
`endif
  output logic        busy
);
  // state  | meaning
  // S_IDLE | waiting for a request, ready goes to the arbitration winner
  // S_EXEC | latched operands on the ALU, counting down to capture
  // S_RESP | result held until the owning port consumes it
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic        r_owner;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_shamt;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_result;
  logic        r_illegal;
  logic        r_busy;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_idle;
  logic        w_rsp_done;
  logic [4:0]  w_dist;
  logic [31:0] w_res;
  logic        w_illegal;

  // Port 0 wins when alone, under fixed priority, or when port 1 was granted last.
  assign w_gnt0     = req0_valid && (!req1_valid || FIXED_PRIO || r_last_grant);
  assign w_gnt1     = req1_valid && !w_gnt0;
  assign w_idle     = (r_state == S_IDLE);
  assign req0_ready = w_idle && w_gnt0;
  assign req1_ready = w_idle && w_gnt1;
  assign w_rsp_done = (r_rsp0_valid && rsp0_ready) || (r_rsp1_valid && rsp1_ready);

  // A zero shift amount selects a shift of 0 or 1 from operand b bit 0.
  assign w_dist = (r_shamt != 5'd0) ? r_shamt : {4'd0, r_b[0]};

  always_comb begin
    w_res     = 32'd0;
    w_illegal = 1'b0;
    case (r_op)
      4'd0:    w_res = r_a + r_b;
      4'd1:    w_res = r_a - r_b;
      4'd2:    w_res = r_a & r_b;
      4'd3:    w_res = r_a | r_b;
      4'd4:    w_res = r_a ^ r_b;
      4'd5:    w_res = ~r_a;
      4'd6:    w_res = r_a << w_dist;
      4'd7:    w_res = $unsigned($signed(r_a) >>> w_dist);
      4'd8:    w_res = r_a >> w_dist;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= 4'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_shamt      <= 5'd0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_result     <= 32'd0;
      r_illegal    <= 1'b0;
      r_busy       <= 1'b0;
`ifdef ALU_FLAGS_EN
      rsp_zero     <= 1'b0;
      rsp_neg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_op         <= w_gnt1 ? req1_op    : req0_op;
            r_a          <= w_gnt1 ? req1_a     : req0_a;
            r_b          <= w_gnt1 ? req1_b     : req0_b;
            r_shamt      <= w_gnt1 ? req1_shamt : req0_shamt;
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_cnt        <= LP_CNT_INIT;
            r_busy       <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_result     <= w_res;
            r_illegal    <= w_illegal;
`ifdef ALU_FLAGS_EN
            rsp_zero     <= (w_res == 32'd0);
            rsp_neg      <= w_res[31];
`endif
            r_rsp0_valid <= !r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_done) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp_result  = r_result;
  assign rsp_illegal = r_illegal;
  assign busy        = r_busy;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed spec vectors plus random traffic against a reference model.
module tb_alu_share_ctrl;
  localparam int EXEC       = 3;
  localparam bit FIXED_PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
  logic        busy;
`ifdef ALU_FLAGS_EN
  logic        rsp_zero, rsp_neg;
`endif

  alu_share_ctrl #(.EXEC_CYCLES(EXEC), .FIXED_PRIO(FIXED_PRIO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_illegal(rsp_illegal),
`ifdef ALU_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        ill;
    int          k;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   outstanding = 1'b0;
  bit   m_last = 1'b1;
  int   out_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference ALU: {illegal, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    int unsigned d;
    logic [31:0] r;
    d = (sh != 5'd0) ? int'(sh) : int'(b[0]);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a * (32'd1 << d);
      4'd7: r = (a >> d) | (a[31] ? ~(32'hFFFF_FFFF >> d) : 32'd0);
      4'd8: r = a >> d;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r};
  endfunction

  task automatic push_exp(input int p);
    exp_t e;
    logic [32:0] m;
    if (p == 0) m = ref_alu(req0_op, req0_a, req0_b, req0_shamt);
    else        m = ref_alu(req1_op, req1_a, req1_b, req1_shamt);
    e.port = p;
    e.res  = m[31:0];
    e.ill  = m[32];
    e.k    = cyc + 1;
    sb_q.push_back(e);
  endtask

  // One clock: check arbitration at the falling edge, update model, return just after the rising edge.
  task automatic step();
    bit e0, e1;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    chk("busy", {31'd0, busy}, {31'd0, outstanding});
    if (!rst_n) begin
      outstanding = 1'b0;
      m_last      = 1'b1;
      out_cycles  = 0;
      sb_q.delete();
    end else begin
      if (!outstanding) begin
        if (req0_valid && (!req1_valid || FIXED_PRIO || m_last)) e0 = 1'b1;
        else if (req1_valid) e1 = 1'b1;
      end
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
      if (outstanding && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)))
        outstanding = 1'b0;
      if (e0 || e1) begin
        push_exp(e1 ? 1 : 0);
        m_last      = e1;
        outstanding = 1'b1;
      end
      if (outstanding) begin
        out_cycles++;
        if (out_cycles > 80) begin
          checks++;
          errors++;
          $display("FAIL rsp_timeout: no response within 80 cycles (cycle %0d)", cyc);
          outstanding = 1'b0;
          sb_q.delete();
        end
      end else begin
        out_cycles = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 1'b0;
    end else begin
      chk("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      if (rsp0_valid || rsp1_valid) begin
        if (!have_cur) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: actual=response required=none (cycle %0d)", cyc);
          end else begin
            cur      = sb_q.pop_front();
            have_cur = 1'b1;
            chk("rsp_latency", 32'(cyc), 32'(cur.k + EXEC));
          end
        end
        if (have_cur) begin
          chk("rsp_port", {30'd0, rsp1_valid, rsp0_valid}, (cur.port == 1) ? 32'd2 : 32'd1);
          chk("rsp_result", rsp_result, cur.res);
          chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, cur.ill});
`ifdef ALU_FLAGS_EN
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, cur.ill | (cur.res == 32'd0)});
          chk("rsp_neg", {31'd0, rsp_neg}, {31'd0, ~cur.ill & cur.res[31]});
`endif
        end
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) have_cur = 1'b0;
      end
    end
  end

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    if (p == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
    end
  endtask

  task automatic rand_req(input int p);
    logic [3:0] op;
    logic [4:0] sh;
    op = ($urandom % 5 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    sh = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
    set_req(p, op, $urandom, $urandom, sh);
  endtask

  task automatic run_one(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(p, op, a, b, sh);
    for (int i = 0; i < 20 && !outstanding; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 60 && outstanding; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0; req0_shamt = 5'd0;
    req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0; req1_shamt = 5'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_illegal", {31'd0, rsp_illegal}, 32'd0);
`ifdef ALU_FLAGS_EN
    chk("rst_flags", {30'd0, rsp_zero, rsp_neg}, 32'd0);
`endif

    run_one(0, 4'd0, 32'd5, 32'd7, 5'd0);
    run_one(1, 4'd1, 32'd3, 32'd5, 5'd0);
    run_one(0, 4'd7, 32'h8000_0000, 32'd0, 5'd4);
    run_one(1, 4'd7, 32'h8000_0000, 32'd1, 5'd0);
    run_one(0, 4'd6, 32'h1, 32'd2, 5'd0);
    run_one(1, 4'd8, 32'h8000_0000, 32'd0, 5'd31);
    run_one(0, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
    run_one(1, 4'd5, 32'h0F0F_0000, 32'hFFFF_FFFF, 5'd0);

    // Contention with both requesters always valid.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 8 * (EXEC + 2); i++) begin
      if (req0_ready) rand_req(0);
      if (req1_ready) rand_req(1);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 40 && outstanding; i++) step();

    // Backpressure: port 0 result held while port 1 keeps asking.
    rsp0_ready = 1'b0;
    set_req(0, 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0);
    for (int i = 0; i < 20 && !outstanding; i++) step();
    req0_valid = 1'b0;
    rand_req(1);
    for (int i = 0; i < 20 && !rsp0_valid; i++) step();
    repeat (5) step();
    rsp0_ready = 1'b1;
    for (int i = 0; i < 60 && outstanding; i++) step();
    req1_valid = 1'b0;
    for (int i = 0; i < 60 && outstanding; i++) step();

    // Reset in the middle of EXEC after a port-0 grant; port 0 must win first afterwards.
    req0_valid = 1'b0; req1_valid = 1'b0;
    set_req(0, 4'd0, 32'd1, 32'd2, 5'd0);
    for (int i = 0; i < 20 && !outstanding; i++) step();
    req0_valid = 1'b0;
    step();
    rst_n = 1'b0;
    rand_req(0);
    rand_req(1);
    step();
    rst_n = 1'b1;
    chk("midrst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 60 && outstanding; i++) step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 3 != 0) rand_req(0); else req0_valid = 1'b0;
      if ($urandom % 3 != 0) rand_req(1); else req1_valid = 1'b0;
      rsp0_ready = ($urandom % 4 != 0);
      rsp1_ready = ($urandom % 4 != 0);
      step();
    end

    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 80 && (outstanding || have_cur); i++) step();
    repeat (2) step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
